// File: rtl/poly_voice_allocator_pkg.sv
// -----------------------------------------------------------------------------
// poly_voice_allocator_pkg
// Shared definitions for the polyphonic voice allocator:
//   - clog2        : ceiling log2 used to size the mixer accumulator and indices
//   - SUM_W        : mixer accumulator width for the default configuration
//   - sat_to_width : clamps a wide signed value into a narrower signed range
// -----------------------------------------------------------------------------
package poly_voice_allocator_pkg;

    // Ceiling log2 with a fixed iteration bound so it elaborates as a constant.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int NUM_VOICES_DEF = 3;
    localparam int SAMPLE_W_DEF   = 18;
    localparam int SUM_W          = SAMPLE_W_DEF + clog2(NUM_VOICES_DEF);

    // Clamp v into the signed range of a w-bit number. Operates at 64 bits so
    // one helper serves every accumulator width; callers truncate the result.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                         input int unsigned      w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/poly_voice_allocator_voice_slot.sv
// -----------------------------------------------------------------------------
// poly_voice_allocator_voice_slot
// State for one voice: beat-duration countdown, note register, one-cycle load
// pulse toward the external note player, and the mixer's per-voice ready flag.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   i_load          : this voice was chosen for the current request
//   i_note, i_dur   : note code / duration to capture on load
//   i_tick          : beat strobe already qualified by play_enable
//   i_win_open      : generate_next_sample, opens a mixer window
//   i_ready         : sample-ready pulse from this voice's note player
//   o_count         : remaining beats (0 = idle)
//   o_note          : registered note code
//   o_load          : one-cycle load pulse, same edge as the capture
//   o_flag          : sample for the current window has arrived
// -----------------------------------------------------------------------------
module poly_voice_allocator_voice_slot #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [NOTE_W-1:0] i_note,
    input  logic [DUR_W-1:0]  i_dur,
    input  logic              i_tick,
    input  logic              i_win_open,
    input  logic              i_ready,
    output logic [DUR_W-1:0]  o_count,
    output logic [NOTE_W-1:0] o_note,
    output logic              o_load,
    output logic              o_flag
);

    logic [DUR_W-1:0]  r_count;
    logic [NOTE_W-1:0] r_note;
    logic              r_load;
    logic              r_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_note  <= '0;
            r_load  <= 1'b0;
            r_flag  <= 1'b0;
        end else begin
            r_load <= i_load;
            // A load overrides a coincident beat: the new note gets its full length.
            if (i_load) begin
                r_count <= i_dur;
                r_note  <= i_note;
            end else if (i_tick && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end
            // Opening a new window beats a same-cycle ready pulse from the old one.
            if (i_win_open) begin
                r_flag <= 1'b0;
            end else if (i_ready) begin
                r_flag <= 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_note  = r_note;
    assign o_load  = r_load;
    assign o_flag  = r_flag;

endmodule

// File: rtl/poly_voice_allocator.sv
// -----------------------------------------------------------------------------
// poly_voice_allocator
// Assigns incoming notes to NUM_VOICES external note players, counts each
// voice down in beats, steals (or drops) when all voices are busy, and mixes
// the returned voice samples into one scaled, saturated output sample.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   play_enable                     : run; low freezes counters and ignores loads
//   load_new_note/note_to_load/duration : note request
//   beat                            : beat strobe
//   generate_next_sample            : codec request, opens a mixer window
//   voice_sample_in/voice_ready_in  : per-voice samples and ready pulses
//   voice_note/voice_load           : per-voice note and load pulse
//   voice_active/all_done           : combinational activity status
//   final_sample/sample_ready       : mixed output and its valid pulse
//   note_dropped/note_stolen        : allocation outcome pulses
// -----------------------------------------------------------------------------
module poly_voice_allocator
    import poly_voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int SAMPLE_W   = 18,
    parameter int MIX_SHIFT  = 0,
    parameter int STEAL_EN   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play_enable,
    input  logic                           load_new_note,
    input  logic [NOTE_W-1:0]              note_to_load,
    input  logic [DUR_W-1:0]               duration,
    input  logic                           beat,
    input  logic                           generate_next_sample,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample_in,
    input  logic [NUM_VOICES-1:0]          voice_ready_in,
    output logic [NUM_VOICES*NOTE_W-1:0]   voice_note,
    output logic [NUM_VOICES-1:0]          voice_load,
    output logic [NUM_VOICES-1:0]          voice_active,
    output logic [SAMPLE_W-1:0]            final_sample,
    output logic                           sample_ready,
    output logic                           all_done,
    output logic                           note_dropped,
    output logic                           note_stolen
);

    localparam int ACC_W = SAMPLE_W + clog2(NUM_VOICES);
    localparam int IDX_W = clog2(NUM_VOICES);

    logic [DUR_W-1:0]        w_count [NUM_VOICES];
    logic signed [ACC_W-1:0] w_samp_ext [NUM_VOICES];
    logic [NUM_VOICES-1:0]   w_flag;
    logic [NUM_VOICES-1:0]   w_load_vec;
    logic [NUM_VOICES-1:0]   w_satisfied;
    logic                    w_request;
    logic                    w_found_idle;
    logic                    w_accept;
    logic                    w_steal;
    logic                    w_drop;
    logic                    w_window_done;
    logic [IDX_W-1:0]        w_idle_idx;
    logic [IDX_W-1:0]        w_min_idx;
    logic [IDX_W-1:0]        w_target;
    logic [DUR_W-1:0]        w_min_cnt;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shifted;
    logic signed [63:0]      w_wide;
    logic [SAMPLE_W-1:0]     w_mixed;

    logic                    r_pending;
    logic                    r_sample_ready;
    logic [SAMPLE_W-1:0]     r_final;
    logic                    r_stolen;
    logic                    r_dropped;

    // ---------------- allocation ----------------
    assign w_request = load_new_note & play_enable & (duration != '0);

    // Lowest idle voice, and the voice with the smallest count (strict '<'
    // keeps the lowest index on ties).
    always_comb begin
        w_found_idle = 1'b0;
        w_idle_idx   = '0;
        w_min_idx    = '0;
        w_min_cnt    = w_count[0];
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!w_found_idle && (w_count[i] == '0)) begin
                w_found_idle = 1'b1;
                w_idle_idx   = IDX_W'(i);
            end
            if (w_count[i] < w_min_cnt) begin
                w_min_cnt = w_count[i];
                w_min_idx = IDX_W'(i);
            end
        end
    end

    assign w_target = w_found_idle ? w_idle_idx : w_min_idx;
    assign w_steal  = w_request & ~w_found_idle & (STEAL_EN != 0);
    assign w_drop   = w_request & ~w_found_idle & (STEAL_EN == 0);
    assign w_accept = w_request & (w_found_idle | (STEAL_EN != 0));

    // ---------------- per-voice slots ----------------
    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            assign w_load_vec[gi] = w_accept && (w_target == IDX_W'(gi));

            poly_voice_allocator_voice_slot #(
                .NOTE_W (NOTE_W),
                .DUR_W  (DUR_W)
            ) u_slot (
                .clk        (clk),
                .reset      (reset),
                .i_load     (w_load_vec[gi]),
                .i_note     (note_to_load),
                .i_dur      (duration),
                .i_tick     (beat & play_enable),
                .i_win_open (generate_next_sample),
                .i_ready    (voice_ready_in[gi]),
                .o_count    (w_count[gi]),
                .o_note     (voice_note[gi*NOTE_W +: NOTE_W]),
                .o_load     (voice_load[gi]),
                .o_flag     (w_flag[gi])
            );

            assign voice_active[gi] = (w_count[gi] != '0);
            // Idle voices never send a sample, so they never hold up a window.
            assign w_satisfied[gi]  = w_flag[gi] | ~voice_active[gi];
            assign w_samp_ext[gi]   = voice_active[gi]
                ? {{(ACC_W-SAMPLE_W){voice_sample_in[gi*SAMPLE_W+SAMPLE_W-1]}},
                   voice_sample_in[gi*SAMPLE_W +: SAMPLE_W]}
                : '0;
        end
    endgenerate

    assign all_done = ~(|voice_active);

    // ---------------- mixer ----------------
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_sum = w_sum + w_samp_ext[i];
        end
    end

    assign w_shifted     = w_sum >>> MIX_SHIFT;
    assign w_wide        = {{(64-ACC_W){w_shifted[ACC_W-1]}}, w_shifted};
    assign w_mixed       = SAMPLE_W'(sat_to_width(w_wide, SAMPLE_W));
    assign w_window_done = r_pending & (&w_satisfied);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending      <= 1'b0;
            r_sample_ready <= 1'b0;
            r_final        <= '0;
            r_stolen       <= 1'b0;
            r_dropped      <= 1'b0;
        end else begin
            r_sample_ready <= w_window_done;
            if (w_window_done) begin
                r_final <= w_mixed;
            end
            // A fresh request re-arms the window even if the old one just closed.
            r_pending <= generate_next_sample | (r_pending & ~w_window_done);
            r_stolen  <= w_steal;
            r_dropped <= w_drop;
        end
    end

    assign final_sample = r_final;
    assign sample_ready = r_sample_ready;
    assign note_stolen  = r_stolen;
    assign note_dropped = r_dropped;

endmodule

// File: doc/poly_voice_allocator.md
Name: poly_voice_allocator

Overview:
- Parametrised polyphonic voice manager; successor to the fixed three-voice chord player.
- Takes the song reader's note stream and assigns each note to one of NUM_VOICES external note_player instances.
- Runs a per-voice duration counter and steals a voice when all are busy.
- Mixes the returned voice samples into one scaled, saturated sample for the codec path.

Parameters:
NUM_VOICES, 3, number of voice slots (2..8)
NOTE_W, 6, note code width
DUR_W, 6, duration width in beats
SAMPLE_W, 18, signed sample width in and out
MIX_SHIFT, 0, arithmetic right shift applied to the wide sum before saturation
STEAL_EN, 1, 1 = steal a voice when none is idle; 0 = drop the new note

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
play_enable  in  1  high = run; low = freeze counters and ignore loads
load_new_note  in  1  one-cycle request to start a note
note_to_load  in  NOTE_W  note code for the request
duration  in  DUR_W  note length in beats
beat  in  1  1/48 s beat strobe
generate_next_sample  in  1  codec request strobe
voice_sample_in  in  NUM_VOICES*SAMPLE_W  per-voice signed samples, voice 0 in the LSBs
voice_ready_in  in  NUM_VOICES  per-voice sample-ready pulses
voice_note  out  NUM_VOICES*NOTE_W  registered note per voice
voice_load  out  NUM_VOICES  one-cycle load pulse per voice
voice_active  out  NUM_VOICES  voice count != 0
final_sample  out  SAMPLE_W  registered mixed sample
sample_ready  out  1  one-cycle pulse, final_sample valid
all_done  out  1  no voice active
note_dropped  out  1  one-cycle pulse, request discarded
note_stolen  out  1  one-cycle pulse, an active voice was overwritten

Behaviour:
- Reset values: all counts 0, voice_note 0, voice_load 0, final_sample 0, sample_ready 0, note_dropped 0, note_stolen 0, ready flags 0, pending 0. all_done resets to 1.
- Requests are evaluated only when load_new_note && play_enable. A request with play_enable low is ignored silently.
- A request with duration==0 is ignored. No pulses are generated.
- Allocation:
  - The target is the lowest-index voice with count==0.
  - If there is none and STEAL_EN=1, the target is the voice with the smallest count; ties go to the lowest index. note_stolen pulses.
  - If there is none and STEAL_EN=0, nothing changes and note_dropped pulses.
- On accept, the next edge sets target count<=duration and voice_note<=note_to_load. voice_load[target] pulses on that same edge (latency 1).
- On each beat with play_enable high, every voice with count!=0 decrements by 1. Zero does not wrap.
- Simultaneous load and beat on the target voice: the load wins, with no decrement that cycle. Other voices still decrement.
- With play_enable low, counts and voice_note hold. Mixing continues.
- voice_active and all_done are combinational from the counts.
- Mixer window:
  - generate_next_sample sets pending and clears all per-voice ready flags.
  - voice_ready_in[i] sets flag i.
  - Inactive voices count as ready.
  - If a generate_next_sample and a voice_ready_in pulse land in the same cycle, the clear wins.
- When pending is set and every flag is satisfied:
  - Sum the active voices' sign-extended samples at width SAMPLE_W+clog2(NUM_VOICES); inactive voices contribute 0.
  - Arithmetic shift right by MIX_SHIFT.
  - Saturate to SAMPLE_W signed.
  - Register into final_sample, pulse sample_ready for one cycle, and clear pending.
- Exactly one sample_ready is produced per generate_next_sample window.
- final_sample holds between pulses.
- Asynchronous reset mid-note or mid-window returns everything to reset values immediately. No sample_ready pulse follows reset.

Decomposition:
- Shared package holds:
  - localparam SUM_W = SAMPLE_W + clog2(NUM_VOICES)
  - a clog2 function
  - the saturation helper
- One natural sub-module: voice_slot, instantiated once per voice in a generate loop. It holds the count register, the voice_note register, the load pulse and the ready flag.
- The allocator priority/steal search and the mixer adder tree stay in the top level.

Test Plan:
- Three loads with NUM_VOICES=3, durations 4, 8, 2 -> voice_load pulses on voices 0, 1, 2 in order. After 2 beats voice 2 is inactive. After 4 beats voice 0 is inactive. all_done=1 after 8 beats.
- All three voices busy with counts 5, 3, 3 and STEAL_EN=1, load note 12 dur 7 -> voice 1 is reloaded to 7 with note 12 and note_stolen pulses. With STEAL_EN=0 -> note_dropped pulses and the counts are unchanged.
- Load and beat in the same cycle on an idle voice 0, duration 6 -> count0=6, not 5. Busy voices decrement by 1.
- play_enable=0 across 3 beats plus one load -> counts unchanged and no voice_load. Resuming play_enable continues the countdown from the held values.
- Voices 0 and 1 active with samples 0x1FFFF and 0x1FFFF, MIX_SHIFT=0 -> final_sample saturates to 0x1FFFF. With samples -131072 and -5 -> 0x20000. sample_ready pulses one cycle after the later of the two ready pulses.
- Reset asserted asynchronously while pending with 2 voices active -> all outputs return to reset values before the next edge. No sample_ready follows reset.
